// File: rtl/sd_cmd_tx_pkg.sv
// Shared constants, state encoding and the serial CRC7 step for the SD CMD line.
package sd_cmd_tx_pkg;

  localparam int unsigned TOKEN_BITS   = 48;
  localparam int unsigned CONTENT_BITS = 40;
  localparam logic [6:0]  CRC7_POLY    = 7'h09;

  localparam logic START_BIT = 1'b0;
  localparam logic TX_BIT    = 1'b1;
  localparam logic END_BIT   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_SEND,
    ST_GAP
  } state_t;

  // One serial step of x^7 + x^3 + 1, MSB-first data.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator; clr has priority over en. Shared with the response receiver.
module sd_crc7
  import sd_cmd_tx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc7_step(crc, din);
    end
  end

endmodule

// File: rtl/sd_cmd_tx.sv
// Host SD command transmitter: serializes start/tx/index/argument/CRC7/end onto CMD,
// then releases the line for GAP_BITS SD clocks before pulsing done.
module sd_cmd_tx
  import sd_cmd_tx_pkg::*;
#(
  parameter int unsigned GAP_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_tick,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] argument,
  output logic        busy,
  output logic        done,
  output logic        cmd_out,
  output logic        cmd_oe
);

  localparam int unsigned GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  state_t                  state, state_n;
  logic [CONTENT_BITS-1:0] shreg, shreg_n;
  logic [5:0]              bit_cnt, bit_cnt_n;
  logic [GW-1:0]           gap_cnt, gap_cnt_n;
  logic                    busy_n, done_n, cmd_out_n, cmd_oe_n;

  logic       crc_clr, crc_en, crc_din;
  logic [6:0] crc;
  logic [2:0] crc_idx;

  sd_crc7 u_crc7 (
    .clk   (clk),
    .reset (reset),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (crc_din),
    .crc   (crc)
  );

  // Counter n (7..1) on the line carries crc[n-1]; we are computing the bit for n = bit_cnt-1.
  assign crc_idx = 3'(bit_cnt - 6'd2);
  assign crc_din = shreg[CONTENT_BITS-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cmd_out <= 1'b1;
      cmd_oe  <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_cnt_n;
      gap_cnt <= gap_cnt_n;
      busy    <= busy_n;
      done    <= done_n;
      cmd_out <= cmd_out_n;
      cmd_oe  <= cmd_oe_n;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    busy_n    = busy;
    done_n    = 1'b0;
    cmd_out_n = cmd_out;
    cmd_oe_n  = cmd_oe;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          shreg_n = {START_BIT, TX_BIT, cmd_index, argument};
          crc_clr = 1'b1;
          busy_n  = 1'b1;
          state_n = ST_ARM;
        end
      end

      ST_ARM: begin
        if (sd_tick) begin
          cmd_oe_n  = 1'b1;
          cmd_out_n = shreg[CONTENT_BITS-1];
          crc_en    = 1'b1;
          shreg_n   = {shreg[CONTENT_BITS-2:0], 1'b0};
          bit_cnt_n = 6'(TOKEN_BITS - 1);
          state_n   = ST_SEND;
        end
      end

      ST_SEND: begin
        if (sd_tick) begin
          if (bit_cnt == 6'd0) begin
            cmd_oe_n  = 1'b0;
            cmd_out_n = 1'b1;
            gap_cnt_n = GW'(GAP_BITS - 1);
            state_n   = ST_GAP;
          end else begin
            bit_cnt_n = bit_cnt - 6'd1;
            if (bit_cnt > 6'd8) begin
              cmd_out_n = shreg[CONTENT_BITS-1];
              crc_en    = 1'b1;
              shreg_n   = {shreg[CONTENT_BITS-2:0], 1'b0};
            end else if (bit_cnt > 6'd1) begin
              cmd_out_n = crc[crc_idx];
            end else begin
              cmd_out_n = END_BIT;
            end
          end
        end
      end

      ST_GAP: begin
        if (sd_tick) begin
          if (gap_cnt == '0) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = ST_IDLE;
          end else begin
            gap_cnt_n = gap_cnt - GW'(1);
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Scoreboard bench for sd_cmd_tx: stimulus queues expected 48-bit tokens, a monitor
// reassembles the CMD line, checks token, gap length and done/busy timing.
module tb_sd_cmd_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        sd_tick = 1'b0;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] argument;
  logic        busy, done, cmd_out, cmd_oe;

  int n_checks = 0;
  int n_fail   = 0;

  logic [47:0] exp_q[$];
  int          tick_mode = 4;
  int          div = 0;

  int          cap_n = 0;
  int          gap_n = -1;
  logic [47:0] cap = '0;
  logic        mon_t;
  logic        done_ok;

  logic hold_out, hold_oe, changed;
  int   hold_n;

  always #5 clk = ~clk;

  sd_cmd_tx #(.GAP_BITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .sd_tick   (sd_tick),
    .start     (start),
    .cmd_index (cmd_index),
    .argument  (argument),
    .busy      (busy),
    .done      (done),
    .cmd_out   (cmd_out),
    .cmd_oe    (cmd_oe)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // sd_tick: 0 = stalled, 1 = every clk, 4 = every fourth clk
  always @(negedge clk) begin
    if (tick_mode == 1) sd_tick = 1'b1;
    else if (tick_mode == 4) begin
      div = (div + 1) % 4;
      sd_tick = (div == 0);
    end else sd_tick = 1'b0;
  end

  // Monitor: one line bit per tick edge while cmd_oe is high, then count the gap.
  always @(posedge clk) begin
    mon_t = sd_tick;
    #1;
    done_ok = 1'b0;
    if (!reset) begin
      cap_n = 0;
      gap_n = -1;
    end else if (mon_t && cmd_oe) begin
      cap   = {cap[46:0], cmd_out};
      cap_n++;
    end else if (mon_t && cap_n > 0) begin
      chk("token_len", cap_n, 48);
      if (exp_q.size() == 0) chk("token_expected", exp_q.size(), 1);
      else chk("token", cap, exp_q.pop_front());
      chk("gap_cmd_out", cmd_out, 1);
      cap_n = 0;
      gap_n = 0;
    end else if (mon_t && gap_n >= 0) begin
      gap_n++;
      if (done) begin
        chk("gap_len", gap_n, 8);
        chk("busy_with_done", busy, 0);
        done_ok = 1'b1;
        gap_n = -1;
      end else if (gap_n >= 8) begin
        chk("done_by_gap_end", done, 1);
        gap_n = -1;
      end
    end
    if (done) chk("done_expected", done_ok, 1);
  end

  task automatic send(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] tok);
    @(negedge clk);
    cmd_index = idx;
    argument  = arg;
    start     = 1'b1;
    exp_q.push_back(tok);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_bound", busy, 0);
  endtask

  task automatic wait_bits(input int nb);
    int n = 0;
    while (cap_n < nb && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("bits_reached", cap_n, nb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    start = 1'b0;
    cmd_index = '0;
    argument  = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_out", cmd_out, 1);
    chk("rst_cmd_oe", cmd_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;

    // sd_tick every 4 clks
    send(6'd0,  32'h0000_0000, 48'h40_0000_0000_95); wait_idle();
    send(6'd17, 32'h0000_0000, 48'h51_0000_0000_55); wait_idle();
    send(6'd8,  32'h0000_01AA, 48'h48_0000_01AA_87); wait_idle();

    // sd_tick tied high; start pulsed mid-token must be ignored
    tick_mode = 1;
    send(6'd55, 32'h0000_0000, 48'h77_0000_0000_65);
    wait_bits(10);
    @(negedge clk);
    cmd_index = 6'd17;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // start coinciding with the gap-completion edge must be ignored
    n = 0;
    while (cmd_oe && n < 200) begin @(negedge clk); n++; end
    chk("oe_released", cmd_oe, 0);
    repeat (7) @(negedge clk);
    cmd_index = 6'd1;
    start = 1'b1;
    @(negedge clk);
    chk("done_on_gap_end", done, 1);
    start = 1'b0;
    repeat (60) @(negedge clk);
    chk("start_at_done_edge_ignored", busy, 0);

    // start in the cycle after done is accepted
    send(6'd55, 32'h0000_0000, 48'h77_0000_0000_65);
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    chk("done_seen", done, 1);
    cmd_index = 6'd1;
    argument  = 32'h0;
    start = 1'b1;
    exp_q.push_back(48'h41_0000_0000_F9);
    @(negedge clk);
    start = 1'b0;
    chk("accept_after_done", busy, 1);
    wait_idle();

    // reset mid-token
    tick_mode = 4;
    send(6'd0, 32'h0000_0000, 48'h40_0000_0000_95);
    wait_bits(20);
    reset = 1'b0;
    #1;
    chk("midrst_oe", cmd_oe, 0);
    chk("midrst_out", cmd_out, 1);
    chk("midrst_busy", busy, 0);
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    reset = 1'b1;
    send(6'd0, 32'h0000_0000, 48'h40_0000_0000_95); wait_idle();

    // sd_tick stalled mid-argument
    send(6'd8, 32'h0000_01AA, 48'h48_0000_01AA_87);
    wait_bits(20);
    tick_mode = 0;
    @(negedge clk);
    hold_out = cmd_out;
    hold_oe  = cmd_oe;
    hold_n   = cap_n;
    changed  = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (cmd_out !== hold_out || cmd_oe !== hold_oe) changed = 1'b1;
    end
    chk("stall_hold", changed, 0);
    chk("stall_oe", cmd_oe, 1);
    chk("stall_no_bits", cap_n, hold_n);
    tick_mode = 4;
    wait_idle();

    repeat (20) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
